bsg_mem_1r3w_sync: RTL



---
 rtl/bsg_mem_1r3w_sync.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bsg_mem_1r3w_sync.sv
// Synchronous RAM with three write ports (priority w2 > w1 > w0) and one registered read port.
// Define BSG_MEM_1R3W_SYNC_COLLISION_CNT_EN to add collision_cnt_o, a saturating write-collision counter.
module bsg_mem_1r3w_sync #(
    parameter int width_p                = -1,
    parameter int els_p                  = -1,
    parameter int read_write_same_addr_p = 0,
    localparam int unsigned width_lp      = (width_p < 1) ? 1 : width_p,
    localparam int unsigned els_lp        = (els_p < 2) ? 2 : els_p,
    localparam int unsigned addr_width_lp = (els_lp == 1) ? 1 : $clog2(els_lp)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     w0_v_i,
    input  logic [addr_width_lp-1:0] w0_addr_i,
    input  logic [width_lp-1:0]      w0_data_i,

    input  logic                     w1_v_i,
    input  logic [addr_width_lp-1:0] w1_addr_i,
    input  logic [width_lp-1:0]      w1_data_i,

    input  logic                     w2_v_i,
    input  logic [addr_width_lp-1:0] w2_addr_i,
    input  logic [width_lp-1:0]      w2_data_i,

    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_lp-1:0]      r_data_o
`ifdef BSG_MEM_1R3W_SYNC_COLLISION_CNT_EN
    ,
    output logic [15:0]              collision_cnt_o
`endif
);

    logic [width_lp-1:0] r_mem [els_lp];
    logic [width_lp-1:0] r_data;
    logic [width_lp-1:0] w_rd_data;
    logic                w_w0_ok;
    logic                w_w1_ok;
    logic                w_w2_ok;
    logic                w_r_ok;

    // Address legality only needs logic when the address space exceeds the entry count.
    if ((1 << addr_width_lp) > els_lp) begin : g_range
        localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_lp - 1);
        assign w_w0_ok = (w0_addr_i <= last_lp);
        assign w_w1_ok = (w1_addr_i <= last_lp);
        assign w_w2_ok = (w2_addr_i <= last_lp);
        assign w_r_ok  = (r_addr_i  <= last_lp);
    end else begin : g_full
        assign w_w0_ok = 1'b1;
        assign w_w1_ok = 1'b1;
        assign w_w2_ok = 1'b1;
        assign w_r_ok  = 1'b1;
    end

    // Read mux; with forwarding enabled the later port overrides, matching write priority.
    always_comb begin
        w_rd_data = r_mem[r_addr_i];
        if (read_write_same_addr_p != 0) begin
            if (w0_v_i && w_w0_ok && (w0_addr_i == r_addr_i)) w_rd_data = w0_data_i;
            if (w1_v_i && w_w1_ok && (w1_addr_i == r_addr_i)) w_rd_data = w1_data_i;
            if (w2_v_i && w_w2_ok && (w2_addr_i == r_addr_i)) w_rd_data = w2_data_i;
        end
    end

    // Storage is never reset; only the read register is. Later NBAs give w2 > w1 > w0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data <= '0;
        end else begin
            if (w0_v_i && w_w0_ok) r_mem[w0_addr_i] <= w0_data_i;
            if (w1_v_i && w_w1_ok) r_mem[w1_addr_i] <= w1_data_i;
            if (w2_v_i && w_w2_ok) r_mem[w2_addr_i] <= w2_data_i;
            if (r_v_i)             r_data           <= w_rd_data;
        end
    end

    assign r_data_o = r_data;

`ifdef BSG_MEM_1R3W_SYNC_COLLISION_CNT_EN
    logic [15:0] r_collision_cnt;
    logic        w_collision;

    assign w_collision = (w0_v_i && w1_v_i && (w0_addr_i == w1_addr_i))
                      || (w0_v_i && w2_v_i && (w0_addr_i == w2_addr_i))
                      || (w1_v_i && w2_v_i && (w1_addr_i == w2_addr_i));

    // One increment per colliding cycle, saturating.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_collision_cnt <= '0;
        end else if (w_collision && (r_collision_cnt != 16'hFFFF)) begin
            r_collision_cnt <= r_collision_cnt + 16'd1;
        end
    end

    assign collision_cnt_o = r_collision_cnt;
`endif

`ifndef SYNTHESIS
    always @(posedge reset_n_i) begin
        $display("bsg_mem_1r3w_sync: width_p=%0d els_p=%0d read_write_same_addr_p=%0d",
                 width_p, els_p, read_write_same_addr_p);
    end

    always @(negedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w0_v_i && !w_w0_ok)) else $error("bsg_mem_1r3w_sync: w0 address %0d out of range", w0_addr_i);
            assert (!(w1_v_i && !w_w1_ok)) else $error("bsg_mem_1r3w_sync: w1 address %0d out of range", w1_addr_i);
            assert (!(w2_v_i && !w_w2_ok)) else $error("bsg_mem_1r3w_sync: w2 address %0d out of range", w2_addr_i);
            assert (!(r_v_i  && !w_r_ok))  else $error("bsg_mem_1r3w_sync: read address %0d out of range", r_addr_i);
            if (read_write_same_addr_p == 0) begin
                assert (!(r_v_i && ((w0_v_i && (w0_addr_i == r_addr_i))
                                 || (w1_v_i && (w1_addr_i == r_addr_i))
                                 || (w2_v_i && (w2_addr_i == r_addr_i)))))
                    else $error("bsg_mem_1r3w_sync: read and write to address %0d in the same cycle", r_addr_i);
            end
        end
    end
`endif

endmodule
